// File: rtl/mux_demux.sv
// ---------------------------------------------------------------------------
// mux_demux : registered 4:1 mux stage feeding a registered 1:4 demux stage
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mux_demux #(
  parameter int DATA_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enb,
  input  logic [DATA_BITS-1:0] entrada0,
  input  logic [DATA_BITS-1:0] entrada1,
  input  logic [DATA_BITS-1:0] entrada2,
  input  logic [DATA_BITS-1:0] entrada3,
  input  logic [1:0]           selectorMux,
  input  logic [1:0]           selectorDemux,
  output logic [DATA_BITS-1:0] salida,
  output logic [DATA_BITS-1:0] salida0,
  output logic [DATA_BITS-1:0] salida1,
  output logic [DATA_BITS-1:0] salida2,
  output logic [DATA_BITS-1:0] salida3
);

  logic [DATA_BITS-1:0] salida_q,  salida_d;
  logic [DATA_BITS-1:0] salida0_q, salida0_d;
  logic [DATA_BITS-1:0] salida1_q, salida1_d;
  logic [DATA_BITS-1:0] salida2_q, salida2_d;
  logic [DATA_BITS-1:0] salida3_q, salida3_d;

  always_comb begin
    salida_d = '0;
    if (enb) begin
      case (selectorMux)
        2'd0:    salida_d = entrada0;
        2'd1:    salida_d = entrada1;
        2'd2:    salida_d = entrada2;
        default: salida_d = entrada3;
      endcase
    end
  end

  // Demux forwards the already-registered mux value, giving the second pipeline stage
  always_comb begin
    salida0_d = '0;
    salida1_d = '0;
    salida2_d = '0;
    salida3_d = '0;
    if (enb) begin
      case (selectorDemux)
        2'd0:    salida0_d = salida_q;
        2'd1:    salida1_d = salida_q;
        2'd2:    salida2_d = salida_q;
        default: salida3_d = salida_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      salida_q  <= '0;
      salida0_q <= '0;
      salida1_q <= '0;
      salida2_q <= '0;
      salida3_q <= '0;
    end else begin
      salida_q  <= salida_d;
      salida0_q <= salida0_d;
      salida1_q <= salida1_d;
      salida2_q <= salida2_d;
      salida3_q <= salida3_d;
    end
  end

  assign salida  = salida_q;
  assign salida0 = salida0_q;
  assign salida1 = salida1_q;
  assign salida2 = salida2_q;
  assign salida3 = salida3_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_demux.sv
// ---------------------------------------------------------------------------
// tb_mux_demux : directed-vector bench for mux_demux plus a short model stream
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mux_demux;

  localparam int DATA_BITS = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enb;
  logic [DATA_BITS-1:0] entrada0, entrada1, entrada2, entrada3;
  logic [1:0]           selectorMux, selectorDemux;
  logic [DATA_BITS-1:0] salida, salida0, salida1, salida2, salida3;

  int n_checks = 0;
  int n_errors = 0;

  mux_demux #(.DATA_BITS(DATA_BITS)) dut (
    .clk          (clk),
    .reset        (reset),
    .enb          (enb),
    .entrada0     (entrada0),
    .entrada1     (entrada1),
    .entrada2     (entrada2),
    .entrada3     (entrada3),
    .selectorMux  (selectorMux),
    .selectorDemux(selectorDemux),
    .salida       (salida),
    .salida0      (salida0),
    .salida1      (salida1),
    .salida2      (salida2),
    .salida3      (salida3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] s, input logic [3:0] o0,
                         input logic [3:0] o1, input logic [3:0] o2, input logic [3:0] o3);
    chk({tag, ".salida"},  32'(salida),  32'(s));
    chk({tag, ".salida0"}, 32'(salida0), 32'(o0));
    chk({tag, ".salida1"}, 32'(salida1), 32'(o1));
    chk({tag, ".salida2"}, 32'(salida2), 32'(o2));
    chk({tag, ".salida3"}, 32'(salida3), 32'(o3));
  endtask

  task automatic set_in(input logic e, input logic [3:0] a0, input logic [3:0] a1,
                        input logic [3:0] a2, input logic [3:0] a3,
                        input logic [1:0] sm, input logic [1:0] sd);
    enb = e; entrada0 = a0; entrada1 = a1; entrada2 = a2; entrada3 = a3;
    selectorMux = sm; selectorDemux = sd;
  endtask

  logic [3:0] m_s, m_s_next;
  logic [3:0] m_o [4];
  logic [3:0] ent [4];
  int         nz;

  initial begin
    reset = 1'b1;
    set_in(1'b1, 4'hF, 4'hF, 4'hF, 4'hF, 2'd0, 2'd0);
    #1;
    chk_all("reset_async", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    tick();
    chk_all("reset_hold", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    reset = 1'b0;

    // Disabled block stays cleared regardless of data/selectors
    set_in(1'b0, 4'b0010, 4'b1010, 4'b0110, 4'b1011, 2'd1, 2'd2);
    for (int i = 0; i < 3; i++) begin
      selectorMux = 2'(i); selectorDemux = 2'(3 - i);
      tick();
      chk_all("enb0", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    end

    // Mux 0 -> demux 3 with two-edge latency
    set_in(1'b1, 4'b1110, 4'b1110, 4'b1100, 4'b1000, 2'd0, 2'd3);
    tick();
    chk_all("m0d3_e1", 4'b1110, 4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    chk_all("m0d3_e2", 4'b1110, 4'h0, 4'h0, 4'h0, 4'b1110);

    selectorMux = 2'd2; selectorDemux = 2'd1;
    tick();
    chk_all("m2d1_e1", 4'b1100, 4'h0, 4'b1110, 4'h0, 4'h0);
    tick();
    chk_all("m2d1_e2", 4'b1100, 4'h0, 4'b1100, 4'h0, 4'h0);

    selectorMux = 2'd1; selectorDemux = 2'd2;
    tick();
    chk_all("sweep12", 4'b1110, 4'h0, 4'h0, 4'b1100, 4'h0);
    selectorMux = 2'd3; selectorDemux = 2'd0;
    tick();
    chk_all("sweep30", 4'b1000, 4'b1110, 4'h0, 4'h0, 4'h0);
    tick();
    chk_all("sweep30b", 4'b1000, 4'b1000, 4'h0, 4'h0, 4'h0);

    // Build salida2=1100, then reset between edges
    selectorMux = 2'd2; selectorDemux = 2'd0;
    tick();
    selectorDemux = 2'd2;
    tick();
    chk_all("pre_reset", 4'b1100, 4'h0, 4'h0, 4'b1100, 4'h0);
    #2 reset = 1'b1;
    #1;
    chk_all("mid_reset", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    tick();
    chk_all("reset_2edges", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    reset = 1'b0;
    selectorMux = 2'd3; selectorDemux = 2'd1;
    tick();
    chk_all("post_reset", 4'b1000, 4'h0, 4'h0, 4'h0, 4'h0);

    // enb toggle: first enabled edge forwards the zero left by the disabled edge
    enb = 1'b0;
    tick();
    chk_all("toggle_off", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    enb = 1'b1; selectorMux = 2'd0; selectorDemux = 2'd3;
    tick();
    chk_all("toggle_on", 4'b1110, 4'h0, 4'h0, 4'h0, 4'h0);

    // Random stream against an independent two-stage reference
    reset = 1'b1;
    #1;
    reset = 1'b0;
    m_s = '0;
    for (int k = 0; k < 4; k++) m_o[k] = '0;
    for (int c = 0; c < 60; c++) begin
      for (int k = 0; k < 4; k++) ent[k] = 4'($urandom_range(0, 15));
      set_in(1'($urandom_range(0, 3) != 0), ent[0], ent[1], ent[2], ent[3],
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      m_s_next = enb ? ent[selectorMux] : 4'h0;
      for (int k = 0; k < 4; k++)
        m_o[k] = (enb && (int'(selectorDemux) == k)) ? m_s : 4'h0;
      m_s = m_s_next;
      tick();
      chk_all("rand", m_s, m_o[0], m_o[1], m_o[2], m_o[3]);
      nz = int'(salida0 != 0) + int'(salida1 != 0) + int'(salida2 != 0) + int'(salida3 != 0);
      chk("rand.onehot", 32'(nz <= 1), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux_demux.md
MUX_DEMUX -- requirements
Module: mux_demux

Interface
REQ-001 Parameter DATA_BITS, default 4: width of every data lane; legal range 1..32.
REQ-002 Clocking and reset are fixed: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high clear of all registers.
REQ-005 enb  input  1  block enable, sampled on clk.
REQ-006 entrada0..entrada3  input  DATA_BITS each  four source lanes.
REQ-007 selectorMux  input  2  selects the source lane: 0 to entrada0, through 3 to entrada3.
REQ-008 selectorDemux  input  2  selects the destination lane: 0 to salida0, through 3 to salida3.
REQ-009 salida  output  DATA_BITS  registered mux-stage output.
REQ-010 salida0..salida3  output  DATA_BITS each  registered demux-stage outputs.
REQ-011 Selector width SHALL stay 2 bits regardless of DATA_BITS; lane count is fixed at 4.

Function
REQ-012 Mux stage: on each rising clk with enb=1, salida SHALL load entrada[selectorMux].
REQ-013 Mux stage: on each rising clk with enb=0, salida SHALL load 0.
REQ-014 Demux stage: on each rising clk with enb=1, salida[selectorDemux] SHALL load the current registered salida, and the other three salidaN SHALL load 0.
REQ-015 Demux stage: on each rising clk with enb=0, salida0..salida3 SHALL all load 0.
REQ-016 Latency: entrada to salida is 1 cycle; entrada to salidaN is 2 cycles.
REQ-017 Each stage SHALL use the selector value sampled at its own edge; selectors are not pipelined.
REQ-018 Source/destination rule: the value at salidaN in cycle t+2 is the input chosen by selectorMux at edge t+1, routed by selectorDemux at edge t+2.
REQ-019 Toggling enb: the first edge with enb=1 after enb=0 loads salida with valid data, and the demux stage forwards the previous value of salida, which is 0.
REQ-020 At most one salidaN SHALL be nonzero in any cycle.
REQ-021 Changing a selector between edges SHALL have no output effect until the next rising clk; there is no combinational input-to-output path.
REQ-022 X or Z on a selector is illegal; behaviour under such input is not specified.
REQ-023 Data SHALL pass through unmodified, with no width conversion and no arithmetic.

Reset
REQ-024 reset=1 SHALL drive salida and salida0..salida3 to 0 immediately, without waiting for clk.
REQ-025 While reset=1, clk edges and enb SHALL have no effect.
REQ-026 On reset deassertion, normal operation SHALL resume at the next rising clk.
REQ-027 Reset asserted mid-stream SHALL discard any in-flight mux-stage data; the first post-reset demux output is 0.

Verification
REQ-028 Reset, then enb=0 with entrada0..3=0010/1010/0110/1011 and any selectors for 3 cycles -> salida and all salidaN remain 0000.
REQ-029 Set enb=1, entrada0..3=1110/1110/1100/1000, selectorMux=0, selectorDemux=3 -> salida=1110 after 1 edge; salida3=1110 and the others 0000 after 2 edges.
REQ-030 Set selectorMux=2 and selectorDemux=1 with the same data -> salida=1100 after 1 edge; salida1=1100 and the others 0000 after the second edge.
REQ-031 Sweep (selectorMux, selectorDemux) through (1,2), (3,0) on consecutive cycles -> salida sequence 1110, 1000; after one more edge salida0=1000 and the others 0000.
REQ-032 Assert reset asynchronously between edges while salida2=1100 -> all outputs 0000 before the next edge; hold reset across 2 edges -> outputs stay 0000.
REQ-033 Run a random stream with enb toggling against a 2-stage reference model -> exact match every cycle, and never more than one nonzero salidaN.
